// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte sources.
// Round-robin grant per byte; one tx_en / req_ready pulse per grant,
// then tracks tx_rdy (fall = accepted, rise = frame done) with a timeout.
// Optional burst locking is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_rdy,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0] state;
  logic [2:0] ptr;
  logic [7:0] timer;
  logic       lock_q;

  logic       win_found;
  logic [2:0] win_id;
  logic [7:0] win_byte;
  logic       win_lock;
  logic       cur_valid;
  logic       grant;

  // Winner select: pointer-relative scan, overridden by a live lock holder.
  // Loops compare against constant indices so every select is static.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    win_byte  = 8'h00;
    win_lock  = 1'b0;
    cur_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
          win_found = 1'b1;
          win_id    = 3'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_id == 3'(i)) cur_valid = req_valid[i];
    if (lock_q && cur_valid) win_id = grant_id;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == 3'(i)) begin
        win_byte = req_data[8*i +: 8];
        win_lock = req_lock[i];
      end
    end
  end

  assign grant = (state == IDLE) && tx_rdy && win_found;
  assign busy  = (state != IDLE);

  // Grant / handshake FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'(NUM_REQ - 1);
      timer     <= 8'h00;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      req_ready <= '0;
      grant_id  <= 3'd0;
      timeout   <= 1'b0;
    end else begin
      tx_en     <= 1'b0;
      req_ready <= '0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data   <= win_byte;
            tx_en     <= 1'b1;
            req_ready <= NUM_REQ'(1) << win_id;
            grant_id  <= win_id;
            ptr       <= win_id;
            timer     <= 8'h00;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Byte is already consumed; on timeout it is dropped, not retried.
          if (!tx_rdy)
            state <= WAIT_DONE;
          else if (timer == 8'(ACK_TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else
            timer <= timer + 8'h01;
        end
        WAIT_DONE: begin
          if (tx_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_LOCK_EN
  // Capture the winner's lock request at each grant.
  always_ff @(posedge clk) begin
    if (rst)        lock_q <= 1'b0;
    else if (grant) lock_q <= win_lock;
  end
`else
  // Locking disabled: pure round-robin, req_lock has no effect.
  logic unused_lock;
  assign lock_q      = 1'b0;
  assign unused_lock = win_lock;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, ACK_TIMEOUT=16).
// Outputs sampled 1 time unit after each rising edge; inputs changed there too.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int ACK = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_lock;
  logic [NR-1:0] req_ready;
  logic          tx_rdy;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic [2:0]    grant_id;
  logic          busy;
  logic          timeout;

  logic          tb_rdy;
  logic          model_en;
  logic [4:0]    mcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Transmitter model: rdy low for 20 cycles after each en pulse.
  always @(posedge clk) begin
    if (rst)               mcnt <= 5'd0;
    else if (tx_en)        mcnt <= 5'd20;
    else if (mcnt != 5'd0) mcnt <= mcnt - 5'd1;
  end
  assign tx_rdy = model_en ? (mcnt == 5'd0) : tb_rdy;

  uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .tx_rdy(tx_rdy),
    .tx_en(tx_en), .tx_data(tx_data), .grant_id(grant_id), .busy(busy),
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : main
    logic          bad;
    int            n;
    int            nr;
    int            ne;
    logic [7:0]    gbyte [5];
    logic [NR-1:0] grdy  [5];
    logic [2:0]    gid   [4];
    logic [7:0]    exp_b [5];
    logic [2:0]    exp_g [4];

    rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0;
    tb_rdy = 1'b1; model_en = 1'b0;
    tick(); tick();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);

    // Single request from 0: grant one cycle after it is sampled.
    rst = 1'b0;
    req_valid = 4'b0001; req_data = 32'h0000_0041;
    tick();
    chk("g0_tx_en", tx_en, 1);
    chk("g0_tx_data", tx_data, 8'h41);
    chk("g0_req_ready", req_ready, 4'b0001);
    chk("g0_grant_id", grant_id, 0);
    chk("g0_busy", busy, 1);

    // tx_rdy stays high: timeout ACK cycles after the tx_en cycle.
    req_valid = 4'b0110; req_data = 32'h00B2_B100;
    tick();
    chk("g0_pulse_end", {tx_en, req_ready}, 0);
    bad = timeout;
    for (int i = 2; i <= ACK - 1; i++) begin
      tick();
      bad |= timeout;
    end
    chk("to_early", bad, 0);
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_idle", busy, 0);

    // Next requester after the timeout is 1.
    tick();
    chk("g1_tx_en", tx_en, 1);
    chk("g1_grant_id", grant_id, 1);
    chk("g1_req_ready", req_ready, 4'b0010);
    chk("g1_tx_data", tx_data, 8'hB1);

    // Normal handshake: rdy falls, then rises -> IDLE.
    req_valid = 4'b0100; tb_rdy = 1'b0;
    tick();
    tb_rdy = 1'b1;
    tick();
    chk("wd_rise_no_en", tx_en, 0);
    chk("wd_rise_idle", busy, 0);

    // Held off while tx_rdy=0 in IDLE.
    tb_rdy = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bad |= tx_en;
    end
    chk("gate_no_en", bad, 0);
    chk("gate_idle", busy, 0);
    tb_rdy = 1'b1;
    tick();
    chk("g2_tx_en", tx_en, 1);
    chk("g2_grant_id", grant_id, 2);
    chk("g2_req_ready", req_ready, 4'b0100);
    chk("g2_tx_data", tx_data, 8'hB2);

    // Reset in WAIT_DONE with a request pending.
    req_valid = 4'b1000; req_data = 32'hC300_0000; tb_rdy = 1'b0;
    tick();
    chk("wd_busy", busy, 1);
    rst = 1'b1; tb_rdy = 1'b1;
    tick();
    chk("mrst_outs", {tx_en, req_ready, timeout, busy}, 0);
    chk("mrst_grant_data", {grant_id, tx_data}, 0);
    tick();
    chk("mrst_no_en", tx_en, 0);
    rst = 1'b0; req_valid = 4'b1001; req_data = 32'hC300_00C0;
    tick();
    chk("post_rst_en", tx_en, 1);
    chk("post_rst_gid", grant_id, 0);

    // Rotation with the transmitter model, all four valid.
    rst = 1'b1;
    tick();
    rst = 1'b0; model_en = 1'b1;
    req_valid = 4'b1111; req_data = 32'h4332_2110;
    exp_b[0] = 8'h10; exp_b[1] = 8'h21; exp_b[2] = 8'h32;
    exp_b[3] = 8'h43; exp_b[4] = 8'h10;
    n = 0; nr = 0; ne = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      tick();
      if (req_ready != 0) nr++;
      if (tx_en) begin
        ne++;
        gbyte[n] = tx_data;
        grdy[n]  = req_ready;
        n++;
      end
    end
    chk("rot_count", n, 5);
    chk("rot_en_vs_ready", ne, nr);
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        chk($sformatf("rot_byte%0d", i), gbyte[i], exp_b[i]);
        chk($sformatf("rot_ready%0d", i), grdy[i], 4'b0001 << (i % 4));
      end
    end

    // Lock: requesters 1 and 3, lock asked on the first two grants of 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1010; req_lock = 4'b0010; req_data = 32'hB300_B100;
`ifdef UART_ARB_LOCK_EN
    exp_g[0] = 3'd1; exp_g[1] = 3'd1; exp_g[2] = 3'd1; exp_g[3] = 3'd3;
`else
    exp_g[0] = 3'd1; exp_g[1] = 3'd3; exp_g[2] = 3'd1; exp_g[3] = 3'd3;
`endif
    n = 0;
    for (int c = 0; c < 400 && n < 4; c++) begin
      tick();
      if (tx_en) begin
        gid[n] = grant_id;
        n++;
        if (n == 2) req_lock = 4'b0000;
      end
    end
    chk("lock_count", n, 4);
    for (int i = 0; i < 4; i++)
      if (i < n) chk($sformatf("lock_gid%0d", i), gid[i], exp_g[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
